ram_fifo_ctrl: RTL and testbench

- FIFO controller that sits directly upstream of the dual-address RAM block.
- Turns a push/pop stream interface into the RAM's write strobe, write address, read strobe, read address and output-enable.
- Tracks occupancy and generates full/empty flags and a read-data-valid strobe aligned with the RAM's registered read output.
- The RAM stays a plain storage array; all queue policy lives here.

---
 rtl/ram_fifo_pkg.sv | 9 +
 rtl/fifo_ptr.sv | 16 +
 rtl/ram_fifo_ctrl.sv | 69 ++++++
 tb/tb_ram_fifo_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: default geometry and pointer wrap helper shared by the FIFO controller.
package ram_fifo_pkg;
   localparam int FIFO_W = 128;
   localparam int FIFO_N = 8;
   localparam int FIFO_AN = 7;
   function automatic int wrap_inc(input int p, input int depth);
      return (p == depth - 1) ? 0 : p + 1;
   endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: a_n-bit pointer that advances on en and wraps from w-1 to 0 for any depth w.
module fifo_ptr
   import ram_fifo_pkg::*;
#(
   parameter int w = FIFO_W,
   parameter int a_n = FIFO_AN
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           en,
   output logic [a_n-1:0] q
);
   always_ff @(posedge CLK or posedge RST)
      if (RST) q <= '0;
      else if (en) q <= a_n'(wrap_inc(int'(q), w));
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: push/pop queue policy in front of a dual-address RAM with registered read.
// Define RAM_FIFO_ERR_EN to add sticky ovf/udf error outputs.
module ram_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter int w = FIFO_W,
   parameter int n = FIFO_N,
   parameter int a_n = FIFO_AN
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           push,
   input  logic [n-1:0]   din,
   input  logic           pop,
   output logic           full,
   output logic           empty,
   output logic [a_n:0]   count,
   output logic           dval,
   output logic [n-1:0]   dout,
   input  logic [n-1:0]   ram_q,
   output logic           ram_wr,
   output logic [a_n-1:0] ram_addr_w,
   output logic [n-1:0]   ram_di,
   output logic           ram_rd,
   output logic [a_n-1:0] ram_addr_r,
   output logic           ram_oe
`ifdef RAM_FIFO_ERR_EN
   ,
   output logic           ovf,
   output logic           udf
`endif
);
   logic push_acc, pop_acc;
   logic [a_n:0] count_nxt;
   assign push_acc = push & ~full;
   assign pop_acc = pop & ~empty;
   assign ram_wr = push_acc;
   assign ram_di = din;
   assign ram_rd = pop_acc;
   assign ram_oe = RST;
   assign dout = ram_q;
   assign count_nxt = (push_acc && !pop_acc) ? count + 1'b1 :
                      (pop_acc && !push_acc) ? count - 1'b1 : count;
   fifo_ptr #(.w(w), .a_n(a_n)) u_wptr (.CLK(CLK), .RST(RST), .en(push_acc), .q(ram_addr_w));
   fifo_ptr #(.w(w), .a_n(a_n)) u_rptr (.CLK(CLK), .RST(RST), .en(pop_acc), .q(ram_addr_r));
   // Flags come from the next count so they are registered yet track count exactly.
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         count <= '0;
         empty <= 1'b1;
         full <= 1'b0;
         dval <= 1'b0;
      end else begin
         count <= count_nxt;
         empty <= count_nxt == '0;
         full <= count_nxt == (a_n+1)'(w);
         dval <= pop_acc;
      end
`ifdef RAM_FIFO_ERR_EN
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (push && full) ovf <= 1'b1;
         if (pop && empty) udf <= 1'b1;
      end
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed vectors for a w=4 and a w=5 controller, each driving a behavioural RAM.
module tb_ram_fifo_ctrl;
   logic CLK = 1'b0, RST = 1'b1;
   logic p4 = 0, o4 = 0, p5 = 0, o5 = 0;
   logic [7:0] d4 = 0, d5 = 0;
   logic f4, e4, dv4, wr4, rd4, oe4, f5, e5, dv5, wr5, rd5, oe5;
   logic [2:0] c4;
   logic [3:0] c5;
   logic [7:0] q4, q5, do4, do5, di4, di5;
   logic [1:0] aw4, ar4;
   logic [2:0] aw5, ar5;
   logic [7:0] m4 [4];
   logic [7:0] m5 [8];
`ifdef RAM_FIFO_ERR_EN
   logic ov4, ud4, ov5, ud5;
`endif
   int errors = 0, checks = 0;

   always #5 CLK = ~CLK;

   always_ff @(posedge CLK) begin
      if (wr4) m4[aw4] <= di4;
      if (rd4) q4 <= m4[ar4];
      if (wr5) m5[aw5] <= di5;
      if (rd5) q5 <= m5[ar5];
   end

   ram_fifo_ctrl #(.w(4), .n(8), .a_n(2)) u4 (
      .CLK(CLK), .RST(RST), .push(p4), .din(d4), .pop(o4), .full(f4), .empty(e4), .count(c4),
      .dval(dv4), .dout(do4), .ram_q(q4), .ram_wr(wr4), .ram_addr_w(aw4), .ram_di(di4),
      .ram_rd(rd4), .ram_addr_r(ar4), .ram_oe(oe4)
`ifdef RAM_FIFO_ERR_EN
      , .ovf(ov4), .udf(ud4)
`endif
   );
   ram_fifo_ctrl #(.w(5), .n(8), .a_n(3)) u5 (
      .CLK(CLK), .RST(RST), .push(p5), .din(d5), .pop(o5), .full(f5), .empty(e5), .count(c5),
      .dval(dv5), .dout(do5), .ram_q(q5), .ram_wr(wr5), .ram_addr_w(aw5), .ram_di(di5),
      .ram_rd(rd5), .ram_addr_r(ar5), .ram_oe(oe5)
`ifdef RAM_FIFO_ERR_EN
      , .ovf(ov5), .udf(ud5)
`endif
   );

   typedef struct {
      logic push, pop;
      logic [7:0] din;
      logic wr, rd;
      logic [1:0] aw, ar;
      logic [2:0] cnt;
      logic emp, ful, dv;
      logic [7:0] dq;
   } vec_t;
   vec_t tv [16];

   function automatic vec_t mk(int ps, int pp, int di, int wr, int rd, int aw, int ar,
                               int c, int e, int f, int dv, int dq);
      vec_t v;
      v.push = ps[0]; v.pop = pp[0]; v.din = di[7:0]; v.wr = wr[0]; v.rd = rd[0];
      v.aw = aw[1:0]; v.ar = ar[1:0]; v.cnt = c[2:0]; v.emp = e[0]; v.ful = f[0];
      v.dv = dv[0]; v.dq = dq[7:0];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int wrap_aw [4];
      wrap_aw = '{3, 4, 0, 1};
      //        ps pp din  wr rd aw ar cnt e f dv dq
      tv[0]  = mk(1, 0, 'h11, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      tv[1]  = mk(1, 0, 'h22, 1, 0, 1, 0, 2, 0, 0, 0, 0);
      tv[2]  = mk(1, 0, 'h33, 1, 0, 2, 0, 3, 0, 0, 0, 0);
      tv[3]  = mk(1, 0, 'h44, 1, 0, 3, 0, 4, 0, 1, 0, 0);
      tv[4]  = mk(1, 0, 'h55, 0, 0, 0, 0, 4, 0, 1, 0, 0);
      tv[5]  = mk(0, 1, 0,    0, 1, 0, 0, 3, 0, 0, 1, 'h11);
      tv[6]  = mk(0, 1, 0,    0, 1, 0, 1, 2, 0, 0, 1, 'h22);
      tv[7]  = mk(0, 1, 0,    0, 1, 0, 2, 1, 0, 0, 1, 'h33);
      tv[8]  = mk(0, 1, 0,    0, 1, 0, 3, 0, 1, 0, 1, 'h44);
      tv[9]  = mk(0, 1, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0);
      tv[10] = mk(1, 0, 'haa, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      tv[11] = mk(1, 0, 'hbb, 1, 0, 1, 0, 2, 0, 0, 0, 0);
      tv[12] = mk(1, 1, 'hcc, 1, 1, 2, 0, 2, 0, 0, 1, 'haa);
      tv[13] = mk(1, 0, 'hdd, 1, 0, 3, 1, 3, 0, 0, 0, 0);
      tv[14] = mk(1, 0, 'hee, 1, 0, 0, 1, 4, 0, 1, 0, 0);
      tv[15] = mk(1, 1, 'hff, 0, 1, 0, 1, 3, 0, 0, 1, 'hbb);

      repeat (2) @(posedge CLK);
      #1;
      chk("rst_count", 32'(c4), 0);
      chk("rst_empty", 32'(e4), 1);
      chk("rst_full", 32'(f4), 0);
      chk("rst_dval", 32'(dv4), 0);
      chk("rst_oe", 32'(oe4), 1);
      @(negedge CLK) RST = 1'b0;
      #1 chk("run_oe", 32'(oe4), 0);
      tick();

      for (int i = 0; i < 16; i++) begin
         p4 = tv[i].push; o4 = tv[i].pop; d4 = tv[i].din;
         #1;
         chk($sformatf("v%0d_wr", i), 32'(wr4), 32'(tv[i].wr));
         chk($sformatf("v%0d_rd", i), 32'(rd4), 32'(tv[i].rd));
         if (tv[i].wr) chk($sformatf("v%0d_aw", i), 32'(aw4), 32'(tv[i].aw));
         if (tv[i].rd) chk($sformatf("v%0d_ar", i), 32'(ar4), 32'(tv[i].ar));
         tick();
         chk($sformatf("v%0d_count", i), 32'(c4), 32'(tv[i].cnt));
         chk($sformatf("v%0d_empty", i), 32'(e4), 32'(tv[i].emp));
         chk($sformatf("v%0d_full", i), 32'(f4), 32'(tv[i].ful));
         chk($sformatf("v%0d_dval", i), 32'(dv4), 32'(tv[i].dv));
         if (tv[i].dv) chk($sformatf("v%0d_dout", i), 32'(do4), 32'(tv[i].dq));
      end
      p4 = 0; o4 = 0;
`ifdef RAM_FIFO_ERR_EN
      chk("ovf_sticky", 32'(ov4), 1);
      chk("udf_sticky", 32'(ud4), 1);
      chk("ovf_clean", 32'(ov5), 0);
`endif

      for (int i = 0; i < 3; i++) begin
         p5 = 1; d5 = 8'(i + 1);
         #1 chk($sformatf("w5_fill_aw%0d", i), 32'(aw5), 32'(i));
         tick();
      end
      p5 = 0;
      for (int i = 0; i < 3; i++) begin
         o5 = 1;
         tick();
         chk($sformatf("w5_pop_dval%0d", i), 32'(dv5), 1);
         chk($sformatf("w5_pop_dout%0d", i), 32'(do5), 32'(i + 1));
      end
      o5 = 0;
      for (int i = 0; i < 4; i++) begin
         p5 = 1; d5 = 8'(8'h50 + i);
         #1 chk($sformatf("w5_wrap_aw%0d", i), 32'(aw5), 32'(wrap_aw[i]));
         tick();
      end
      p5 = 0;
      chk("w5_count4", 32'(c5), 4);
      for (int i = 0; i < 4; i++) begin
         o5 = 1;
         tick();
         chk($sformatf("w5_wrap_dout%0d", i), 32'(do5), 32'(8'h50 + i));
      end
      o5 = 0;
      chk("w5_empty", 32'(e5), 1);

      p4 = 1; o4 = 1; d4 = 8'h12;
      tick();
      p4 = 0; o4 = 0;
      chk("mid_count", 32'(c4), 3);
      chk("mid_dval", 32'(dv4), 1);
      chk("mid_dout", 32'(do4), 32'h cc);
      #2 RST = 1'b1;
      #1;
      chk("arst_count", 32'(c4), 0);
      chk("arst_empty", 32'(e4), 1);
      chk("arst_full", 32'(f4), 0);
      chk("arst_dval", 32'(dv4), 0);
      chk("arst_oe", 32'(oe4), 1);
`ifdef RAM_FIFO_ERR_EN
      chk("arst_ovf", 32'(ov4), 0);
      chk("arst_udf", 32'(ud4), 0);
`endif
      @(negedge CLK) RST = 1'b0;
      #1 chk("post_oe", 32'(oe4), 0);
      tick();
      chk("post_count", 32'(c4), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
